cluster_unpacker: RTL

Decoder for the cluster stream: takes cluster words (strip address plus size) presented one per 160 MHz clock, and rebuilds the 768-bit VFAT partition strip map (vpfs) for each 25 ns frame. It sits downstream of the cluster packer/truncator/priority-encoder chain. It is used for loopback self-check, where the rebuilt vpfs must equal the vpfs originally fed to the packer for every frame that did not overflow. Frames are delimited by the same `latch_pulse` that drives the packer.

---
 rtl/cluster_unpacker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cluster_unpacker.sv
// Rebuilds the per-frame strip map from the cluster word stream; frames are
// delimited by latch_pulse and closed two cycles after the pulse.
module cluster_unpacker #(
  parameter int unsigned MXSTRIPS   = 768,
  parameter int unsigned MXADRBITS  = 10,
  parameter int unsigned MXCNTBITS  = 3,
  parameter int unsigned MXCLUSTERS = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 latch_pulse,
  input  logic                 cluster_valid,
  input  logic [MXADRBITS-1:0] cluster_adr,
  input  logic [MXCNTBITS-1:0] cluster_cnt,
  output logic [MXSTRIPS-1:0]  vpfs_out,
  output logic                 frame_valid,
  output logic [4:0]           cluster_count,
  output logic                 overflow,
  output logic                 bad_adr
);

  localparam int unsigned CW   = 5;
  localparam int unsigned SUMW = MXADRBITS + 1;

  // Stage A: input register
  logic                 lat_a_q, lat_a_d;
  logic                 vld_a_q, vld_a_d;
  logic [MXADRBITS-1:0] adr_a_q, adr_a_d;
  logic [MXCNTBITS-1:0] cnt_a_q, cnt_a_d;

  // Frame in progress and registered outputs
  logic [MXSTRIPS-1:0]  acc_q, acc_d;
  logic [CW-1:0]        ncl_q, ncl_d;
  logic                 ovf_q, ovf_d;
  logic                 bad_q, bad_d;
  logic [MXSTRIPS-1:0]  vpfs_q, vpfs_d;
  logic                 fv_q, fv_d;
  logic [CW-1:0]        cnt_out_q, cnt_out_d;
  logic                 ovf_out_q, ovf_out_d;
  logic                 bad_out_q, bad_out_d;

  logic [MXSTRIPS-1:0]  mask_c;
  logic [SUMW-1:0]      hi_c;
  logic                 adr_bad_c;

  always_comb begin
    lat_a_d = latch_pulse;
    vld_a_d = cluster_valid;
    adr_a_d = cluster_adr;
    cnt_a_d = cluster_cnt;
  end

  // Range decode: every strip compares itself against [adr, adr+cnt]; strips
  // past the top simply do not exist, which gives the silent clip.
  always_comb begin
    hi_c = SUMW'(adr_a_q) + SUMW'(cnt_a_q);
    for (int unsigned i = 0; i < MXSTRIPS; i++) begin
      mask_c[i] = (SUMW'(i) >= SUMW'(adr_a_q)) && (SUMW'(i) <= hi_c);
    end
    adr_bad_c = adr_a_q >= MXADRBITS'(MXSTRIPS);
  end

  // Frame close first, then the same-cycle word qualified against the
  // (possibly just restarted) frame state.
  always_comb begin
    acc_d     = acc_q;
    ncl_d     = ncl_q;
    ovf_d     = ovf_q;
    bad_d     = bad_q;
    vpfs_d    = vpfs_q;
    fv_d      = 1'b0;
    cnt_out_d = cnt_out_q;
    ovf_out_d = ovf_out_q;
    bad_out_d = bad_out_q;
    if (lat_a_q) begin
      vpfs_d    = acc_q;
      cnt_out_d = ncl_q;
      ovf_out_d = ovf_q;
      bad_out_d = bad_q;
      fv_d      = 1'b1;
      acc_d     = '0;
      ncl_d     = '0;
      ovf_d     = 1'b0;
      bad_d     = 1'b0;
    end
    if (vld_a_q) begin
      if (adr_bad_c) begin
        bad_d = 1'b1;
      end else if (ncl_d == CW'(MXCLUSTERS)) begin
        ovf_d = 1'b1;
      end else begin
        acc_d = acc_d | mask_c;
        ncl_d = ncl_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_a_q   <= 1'b0;
      vld_a_q   <= 1'b0;
      adr_a_q   <= '0;
      cnt_a_q   <= '0;
      acc_q     <= '0;
      ncl_q     <= '0;
      ovf_q     <= 1'b0;
      bad_q     <= 1'b0;
      vpfs_q    <= '0;
      fv_q      <= 1'b0;
      cnt_out_q <= '0;
      ovf_out_q <= 1'b0;
      bad_out_q <= 1'b0;
    end else begin
      lat_a_q   <= lat_a_d;
      vld_a_q   <= vld_a_d;
      adr_a_q   <= adr_a_d;
      cnt_a_q   <= cnt_a_d;
      acc_q     <= acc_d;
      ncl_q     <= ncl_d;
      ovf_q     <= ovf_d;
      bad_q     <= bad_d;
      vpfs_q    <= vpfs_d;
      fv_q      <= fv_d;
      cnt_out_q <= cnt_out_d;
      ovf_out_q <= ovf_out_d;
      bad_out_q <= bad_out_d;
    end
  end

  assign vpfs_out      = vpfs_q;
  assign frame_valid   = fv_q;
  assign cluster_count = cnt_out_q;
  assign overflow      = ovf_out_q;
  assign bad_adr       = bad_out_q;

endmodule
